instr_decoder: RTL and testbench

//   Registered RV32I decode stage. Splits a 32-bit instruction into its raw fields
//   (opcode, rd, rs1, rs2, funct3, funct7) and passes the instruction word through.

---
 rtl/instr_decoder.sv | 180 ++++++++++++++++++
 tb/tb_instr_decoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_decoder
// Description : Registered RV32I decode stage. Extracts the raw instruction
//               fields, classifies the encoding format, builds the
//               sign-extended immediate and flags encodings outside the
//               RV32I base opcode set. All outputs are flops (1-cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decoder #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic [XLEN-1:0] instIn,
  output logic            valid_out,
  output logic [XLEN-1:0] instOut,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      fn3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      fn7,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // Format encodings presented on fmt
  localparam logic [2:0] c_FMT_R = 3'd0;
  localparam logic [2:0] c_FMT_I = 3'd1;
  localparam logic [2:0] c_FMT_S = 3'd2;
  localparam logic [2:0] c_FMT_B = 3'd3;
  localparam logic [2:0] c_FMT_U = 3'd4;
  localparam logic [2:0] c_FMT_J = 3'd5;
  localparam logic [2:0] c_FMT_X = 3'd7;

  // RV32I base opcodes. Every one ends in 2'b11, so any word whose low two
  // bits differ falls out of the case below and is flagged illegal.
  localparam logic [6:0] c_OP_OP     = 7'b0110011;
  localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  // Combinational decode of the incoming word
  logic [2:0]      w_fmt;
  logic            w_illegal;
  logic [XLEN-1:0] w_imm;

  // Registered state and its next-state values
  logic            valid_q,   valid_d;
  logic [XLEN-1:0] inst_q,    inst_d;
  logic [6:0]      opcode_q,  opcode_d;
  logic [4:0]      rd_q,      rd_d;
  logic [2:0]      fn3_q,     fn3_d;
  logic [4:0]      rs1_q,     rs1_d;
  logic [4:0]      rs2_q,     rs2_d;
  logic [6:0]      fn7_q,     fn7_d;
  logic [2:0]      fmt_q,     fmt_d;
  logic [XLEN-1:0] imm_q,     imm_d;
  logic            illegal_q, illegal_d;

  // Classify the instruction format from its opcode
  always_comb begin
    w_fmt     = c_FMT_X;
    w_illegal = 1'b0;
    unique case (instIn[6:0])
      c_OP_OP:     w_fmt = c_FMT_R;
      c_OP_OPIMM,
      c_OP_LOAD,
      c_OP_JALR,
      c_OP_SYSTEM,
      c_OP_FENCE:  w_fmt = c_FMT_I;
      c_OP_STORE:  w_fmt = c_FMT_S;
      c_OP_BRANCH: w_fmt = c_FMT_B;
      c_OP_LUI,
      c_OP_AUIPC:  w_fmt = c_FMT_U;
      c_OP_JAL:    w_fmt = c_FMT_J;
      default: begin
        w_fmt     = c_FMT_X;
        w_illegal = 1'b1;
      end
    endcase
  end

  // Assemble the sign-extended immediate for the decoded format
  always_comb begin
    w_imm = '0;
    case (w_fmt)
      c_FMT_I: w_imm = {{20{instIn[31]}}, instIn[31:20]};
      c_FMT_S: w_imm = {{20{instIn[31]}}, instIn[31:25], instIn[11:7]};
      c_FMT_B: w_imm = {{19{instIn[31]}}, instIn[31], instIn[7],
                        instIn[30:25], instIn[11:8], 1'b0};
      c_FMT_U: w_imm = {instIn[31:12], 12'b0};
      c_FMT_J: w_imm = {{11{instIn[31]}}, instIn[31], instIn[19:12],
                        instIn[20], instIn[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  // Next-state: capture on valid_in, otherwise hold everything but valid
  always_comb begin
    valid_d   = valid_in;
    inst_d    = inst_q;
    opcode_d  = opcode_q;
    rd_d      = rd_q;
    fn3_d     = fn3_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    fn7_d     = fn7_q;
    fmt_d     = fmt_q;
    imm_d     = imm_q;
    illegal_d = illegal_q;
    if (valid_in) begin
      // Raw fields come from fixed bit positions regardless of format
      inst_d    = instIn;
      opcode_d  = instIn[6:0];
      rd_d      = instIn[11:7];
      fn3_d     = instIn[14:12];
      rs1_d     = instIn[19:15];
      rs2_d     = instIn[24:20];
      fn7_d     = instIn[31:25];
      fmt_d     = w_fmt;
      imm_d     = w_imm;
      illegal_d = w_illegal;
    end
  end

  // Output register with synchronous active-low reset taking priority
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      inst_q    <= NOP_INSTR;
      opcode_q  <= '0;
      rd_q      <= '0;
      fn3_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      fn7_q     <= '0;
      fmt_q     <= c_FMT_I;
      imm_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      opcode_q  <= opcode_d;
      rd_q      <= rd_d;
      fn3_q     <= fn3_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      fn7_q     <= fn7_d;
      fmt_q     <= fmt_d;
      imm_q     <= imm_d;
      illegal_q <= illegal_d;
    end
  end

  assign valid_out = valid_q;
  assign instOut   = inst_q;
  assign opcode    = opcode_q;
  assign rd        = rd_q;
  assign fn3       = fn3_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign fn7       = fn7_q;
  assign fmt       = fmt_q;
  assign imm       = imm_q;
  assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_decoder
// Description : Directed self-checking bench for instr_decoder using
//               hand-decoded RV32I instruction words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_decoder;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] instIn;
  logic        valid_out;
  logic [31:0] instOut;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  fn3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  fn7;
  logic [2:0]  fmt;
  logic [31:0] imm;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;

  instr_decoder #(
    .XLEN      (32),
    .NOP_INSTR (32'h0000_0013)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .instIn    (instIn),
    .valid_out (valid_out),
    .instOut   (instOut),
    .opcode    (opcode),
    .rd        (rd),
    .fn3       (fn3),
    .rs1       (rs1),
    .rs2       (rs2),
    .fn7       (fn7),
    .fmt       (fmt),
    .imm       (imm),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one valid word, then check every output one edge later
  task automatic vec(input string nm, input logic [31:0] w,
                     input logic [6:0] e_op, input logic [4:0] e_rd,
                     input logic [2:0] e_f3, input logic [4:0] e_rs1,
                     input logic [4:0] e_rs2, input logic [6:0] e_f7,
                     input logic [2:0] e_fmt, input logic [31:0] e_imm,
                     input logic e_ill);
    @(negedge clk);
    valid_in = 1'b1;
    instIn   = w;
    @(posedge clk);
    #1;
    check({nm, ".valid"},   {31'd0, valid_out}, 32'd1);
    check({nm, ".instOut"}, instOut, w);
    check({nm, ".opcode"},  {25'd0, opcode},  {25'd0, e_op});
    check({nm, ".rd"},      {27'd0, rd},      {27'd0, e_rd});
    check({nm, ".fn3"},     {29'd0, fn3},     {29'd0, e_f3});
    check({nm, ".rs1"},     {27'd0, rs1},     {27'd0, e_rs1});
    check({nm, ".rs2"},     {27'd0, rs2},     {27'd0, e_rs2});
    check({nm, ".fn7"},     {25'd0, fn7},     {25'd0, e_f7});
    check({nm, ".fmt"},     {29'd0, fmt},     {29'd0, e_fmt});
    check({nm, ".imm"},     imm,              e_imm);
    check({nm, ".illegal"}, {31'd0, illegal}, {31'd0, e_ill});
  endtask

  // Compare against the documented reset state
  task automatic check_reset(input string nm);
    check({nm, ".valid"},   {31'd0, valid_out}, 32'd0);
    check({nm, ".instOut"}, instOut, 32'h0000_0013);
    check({nm, ".fields"},  {opcode, rd, fn3, rs1, rs2, fn7}, 32'd0);
    check({nm, ".fmt"},     {29'd0, fmt}, 32'd1);
    check({nm, ".imm"},     imm, 32'd0);
    check({nm, ".illegal"}, {31'd0, illegal}, 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    instIn   = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");

    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back valid words: name, word, op, rd, f3, rs1, rs2, f7, fmt, imm, illegal
    vec("add",    32'h0084_8933, 7'h33, 5'd18, 3'd0, 5'd9,  5'd8,  7'h00, 3'd0, 32'd0,         1'b0);
    vec("addi",   32'h1010_0493, 7'h13, 5'd9,  3'd0, 5'd0,  5'd1,  7'h08, 3'd1, 32'd257,       1'b0);
    vec("sw",     32'h0082_A223, 7'h23, 5'd4,  3'd2, 5'd5,  5'd8,  7'h00, 3'd2, 32'd4,         1'b0);
    vec("bltu",   32'h014C_6463, 7'h63, 5'd8,  3'd6, 5'd24, 5'd20, 7'h00, 3'd3, 32'd8,         1'b0);
    vec("jalr",   32'h7FF0_80E7, 7'h67, 5'd1,  3'd0, 5'd1,  5'd31, 7'h3F, 3'd1, 32'h0000_07FF, 1'b0);
    vec("jal0",   32'h0000_006F, 7'h6F, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 3'd5, 32'd0,         1'b0);
    vec("lui",    32'h8723_70B7, 7'h37, 5'd1,  3'd7, 5'd6,  5'd18, 7'h43, 3'd4, 32'h8723_7000, 1'b0);
    vec("auipc",  32'h1000_0917, 7'h17, 5'd18, 3'd0, 5'd0,  5'd0,  7'h08, 3'd4, 32'h1000_0000, 1'b0);
    vec("zero",   32'h0000_0000, 7'h00, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 3'd7, 32'd0,         1'b1);
    vec("addim1", 32'hFFF0_0093, 7'h13, 5'd1,  3'd0, 5'd0,  5'd31, 7'h7F, 3'd1, 32'hFFFF_FFFF, 1'b0);
    vec("beqm4",  32'hFE00_0EE3, 7'h63, 5'd29, 3'd0, 5'd0,  5'd0,  7'h7F, 3'd3, 32'hFFFF_FFFC, 1'b0);
    vec("jalm4",  32'hFFDF_F06F, 7'h6F, 5'd0,  3'd7, 5'd31, 5'd29, 7'h7F, 3'd5, 32'hFFFF_FFFC, 1'b0);
    vec("swm4",   32'hFE00_2E23, 7'h23, 5'd28, 3'd2, 5'd0,  5'd0,  7'h7F, 3'd2, 32'hFFFF_FFFC, 1'b0);
    vec("lo01",   32'h0000_0031, 7'h31, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 3'd7, 32'd0,         1'b1);
    vec("ecall",  32'h0000_0073, 7'h73, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 3'd1, 32'd0,         1'b0);
    vec("fence",  32'h0000_000F, 7'h0F, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 3'd1, 32'd0,         1'b0);
    vec("ones",   32'hFFFF_FFFF, 7'h7F, 5'd31, 3'd7, 5'd31, 5'd31, 7'h7F, 3'd7, 32'd0,         1'b1);
    vec("lw",     32'hFFC4_A303, 7'h03, 5'd6,  3'd2, 5'd9,  5'd28, 7'h7F, 3'd1, 32'hFFFF_FFFC, 1'b0);

    // Drop valid_in for two cycles: outputs hold the lw decode
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      valid_in = 1'b0;
      instIn   = 32'h0084_8933 + k;
      @(posedge clk);
      #1;
      check("hold.valid",   {31'd0, valid_out}, 32'd0);
      check("hold.instOut", instOut, 32'hFFC4_A303);
      check("hold.rd",      {27'd0, rd},  32'd6);
      check("hold.rs2",     {27'd0, rs2}, 32'd28);
      check("hold.fmt",     {29'd0, fmt}, 32'd1);
      check("hold.imm",     imm, 32'hFFFF_FFFC);
    end

    // Reset asserted mid-stream while valid_in is high: reset wins
    vec("sw2", 32'h0082_A223, 7'h23, 5'd4, 3'd2, 5'd5, 5'd8, 7'h00, 3'd2, 32'd4, 1'b0);
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b1;
    instIn   = 32'h0084_8933;
    @(posedge clk);
    #1;
    check_reset("midrst");

    // Recovery after reset release
    @(negedge clk);
    rst_n = 1'b1;
    vec("add2", 32'h0084_8933, 7'h33, 5'd18, 3'd0, 5'd9, 5'd8, 7'h00, 3'd0, 32'd0, 1'b0);

    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    check("end.valid", {31'd0, valid_out}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
